// File: rtl/divider_pkg.sv
// Shared widths, FSM state type and divide-by-zero result constants for divider_8by4.
package divider_pkg;

    localparam int DW = 8;
    localparam int VW = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam logic [DW-1:0] DZ_Q = 8'hFF;
    localparam logic [VW-1:0] DZ_R = 4'h0;

endpackage

// File: rtl/divider_8by4_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step
    import divider_pkg::*;
(
    input  logic [VW-1:0] rem_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);

    logic [VW:0] trial;

    always_comb begin
        trial   = {rem_in, bit_in};
        rem_out = trial;
        q_bit   = 1'b0;
        if (trial >= {1'b0, divisor}) begin
            rem_out = trial - {1'b0, divisor};
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/divider_8by4.sv
// Sequential 8-by-4 unsigned restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes one cycle after accept.
module divider_8by4
    import divider_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] P,
    input  logic [VW-1:0] B,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] Q,
    output logic [VW-1:0] R,
    output logic          dz
);

    div_state_t    state, state_next;
    logic [2:0]    iter_cnt;
    logic [DW-1:0] shift_reg;
    logic [VW-1:0] divisor_reg;
    logic [VW:0]   rem_reg;
    logic [VW:0]   step_rem;
    logic          step_q;
    logic          accept;
    logic          last_iter;
    logic          rem_unused;

    assign accept     = start && (state == IDLE || state == DONE);
    assign last_iter  = (iter_cnt == 3'd7);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign rem_unused = rem_reg[VW];

    div_step u_step (
        .rem_in  (rem_reg[VW-1:0]),
        .bit_in  (shift_reg[DW-1]),
        .divisor (divisor_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept) begin
`ifdef DIV_ZERO_FAST_EN
                    state_next = (B == '0) ? DONE : RUN;
`else
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient register: dividend bits leave
    // at the top while quotient bits enter at the bottom, so after eight shifts it holds Q.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt    <= '0;
            shift_reg   <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            Q           <= '0;
            R           <= '0;
            dz          <= 1'b0;
        end else if (accept) begin
            iter_cnt    <= '0;
            shift_reg   <= P;
            divisor_reg <= B;
            rem_reg     <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (B == '0) begin
                Q  <= DZ_Q;
                R  <= DZ_R;
                dz <= 1'b1;
            end
`endif
        end else if (state == RUN) begin
            iter_cnt  <= iter_cnt + 3'd1;
            shift_reg <= {shift_reg[DW-2:0], step_q};
            rem_reg   <= step_rem;
            if (last_iter) begin
                if (divisor_reg == '0) begin
                    Q  <= DZ_Q;
                    R  <= DZ_R;
                    dz <= 1'b1;
                end else begin
                    Q  <= {shift_reg[DW-2:0], step_q};
                    R  <= step_rem[VW-1:0];
                    dz <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_8by4.sv
// Scoreboard bench for divider_8by4: expected results queued at accept, checked on done.
module tb_divider_8by4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] P;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Q;
    logic [3:0] R;
    logic       dz;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         accept_cyc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   busy_cnt = 0;

    divider_8by4 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .P     (P),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic pushExpected(input logic [7:0] eq, input logic [3:0] er, input logic edz, input int acc);
        exp_t e;
        e.q  = eq;
        e.r  = er;
        e.dz = edz;
        e.accept_cyc = acc;
`ifdef DIV_ZERO_FAST_EN
        e.lat = edz ? 1 : 8;
`else
        e.lat = 8;
`endif
        sb.push_back(e);
    endtask

    // One-cycle start pulse; operands are scrambled afterwards, which must not matter.
    task automatic applyStimulus(input logic [7:0] p, input logic [3:0] b,
                                 input logic [7:0] eq, input logic [3:0] er, input logic edz);
        @(posedge clk);
        #1;
        start = 1'b1;
        P = p;
        B = b;
        pushExpected(eq, er, edz, cyc + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        P = 8'($urandom);
        B = 4'($urandom);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checkOutput("timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("Q", Q, mon_e.q);
                    checkOutput("R", R, mon_e.r);
                    checkOutput("dz", dz, mon_e.dz);
                    checkOutput("latency", cyc - mon_e.accept_cyc, mon_e.lat);
                    checkOutput("busy_cycles", busy_cnt, (mon_e.lat == 1) ? 0 : 8);
                    checkOutput("busy_with_done", busy, 0);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        P     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_Q", Q, 0);
        checkOutput("reset_R", R, 0);
        checkOutput("reset_dz", dz, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        waitIdle();
        applyStimulus(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
        waitIdle();
        applyStimulus(8'd0, 4'd5, 8'd0, 4'd0, 1'b0);
        waitIdle();
        applyStimulus(8'd15, 4'd15, 8'd1, 4'd0, 1'b0);
        waitIdle();
        applyStimulus(8'd15, 4'd0, 8'hFF, 4'd0, 1'b1);
        waitIdle();
        applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        waitIdle();

        // start during RUN must be ignored; any extra done is flagged by the monitor
        applyStimulus(8'd50, 4'd6, 8'd8, 4'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        P = 8'd100;
        B = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
        repeat (12) @(posedge clk);

        // back-to-back: start held through RUN into the DONE cycle
        @(posedge clk);
        #1;
        start = 1'b1;
        P = 8'd100;
        B = 4'd3;
        pushExpected(8'd33, 4'd1, 1'b0, cyc + 1);
        @(posedge clk);
        #1;
        P = 8'd77;
        B = 4'd9;
        pushExpected(8'd8, 4'd5, 1'b0, cyc + 9);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
        waitIdle();

        // reset after the fourth iteration aborts without a done
        @(posedge clk);
        #1;
        start = 1'b1;
        P = 8'd200;
        B = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_Q", Q, 0);
        checkOutput("abort_R", R, 0);
        checkOutput("abort_dz", dz, 0);
        repeat (12) @(posedge clk);
        applyStimulus(8'd9, 4'd2, 8'd4, 4'd1, 1'b0);
        waitIdle();

        // round trip against A*B (+r) products
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    applyStimulus(8'(a * b), 4'(b), 8'hFF, 4'd0, 1'b1);
                    waitIdle();
                end else begin
                    for (int r = 0; r < b; r++) begin
                        applyStimulus(8'(a * b + r), 4'(b), 8'(a), 4'(r), 1'b0);
                        waitIdle();
                    end
                end
            end
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
